// File: rtl/bricks_game_ctrl.sv
// Bricks game sequencer: owns the brick occupancy map, paces the ball mover
// with a divided step strobe, clears struck bricks, keeps score and runs the
// idle/run/pause/won/lost game state machine.
module bricks_game_ctrl #(
  parameter int unsigned STEP_DIV   = 12500000,
  parameter int unsigned DIV_W      = 24,
  parameter int unsigned BRICK_ROWS = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic [3:0]   ball_row,
  input  logic [3:0]   ball_col,
  input  logic [1:0]   ball_dir,
  output logic [191:0] brick_map,
  output logic         ball_step,
  output logic         ball_restart_n,
  output logic [7:0]   score,
  output logic [7:0]   bricks_left,
  output logic [2:0]   game_state
);

  // Game states, numbered as the display side expects them
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_PAUSE = 3'd2;
  localparam logic [2:0] ST_WON   = 3'd3;
  localparam logic [2:0] ST_LOST  = 3'd4;

  // Fresh board: the top BRICK_ROWS rows full, everything below empty
  localparam logic [191:0] INIT_MAP =
    {{(192 - 16 * BRICK_ROWS){1'b0}}, {(16 * BRICK_ROWS){1'b1}}};
  localparam logic [7:0]       INIT_LEFT = 8'(16 * BRICK_ROWS);
  localparam logic [DIV_W-1:0] LAST_DIV  = DIV_W'(STEP_DIV - 1);
  localparam logic [3:0]       LAST_ROW  = 4'd11;
  localparam logic [3:0]       LAST_COL  = 4'd15;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [191:0]     map_q, map_d;
  logic [7:0]       score_q, score_d;
  logic [7:0]       left_q, left_d;
  logic             step_q, step_d;
  logic             restart_n_q, restart_n_d;

  logic             row_ok, v_ok, h_ok;
  logic [3:0]       v_row, h_col;
  logic [7:0]       v_idx, h_idx, d_idx;
  logic             v_hit, h_hit, d_hit, d_clear;
  logic [1:0]       clr_cnt;
  logic [191:0]     clr_map;
  logic [7:0]       left_after;
  logic [8:0]       score_sum;
  logic [7:0]       score_sat;

  // Locate the vertical, horizontal and diagonal neighbours of the ball in its
  // direction of travel and work out which bricks this step knocks out
  always_comb begin
    row_ok = (ball_row <= LAST_ROW);
    if (ball_dir[1]) begin
      v_ok  = (ball_row < LAST_ROW);
      v_row = ball_row + 4'd1;
    end else begin
      v_ok  = row_ok && (ball_row != 4'd0);
      v_row = ball_row - 4'd1;
    end
    if (ball_dir[0]) begin
      h_ok  = (ball_col != LAST_COL);
      h_col = ball_col + 4'd1;
    end else begin
      h_ok  = (ball_col != 4'd0);
      h_col = ball_col - 4'd1;
    end
    v_idx   = {v_row, ball_col};
    h_idx   = {ball_row, h_col};
    d_idx   = {v_row, h_col};
    v_hit   = v_ok && map_q[v_idx];
    h_hit   = row_ok && h_ok && map_q[h_idx];
    d_hit   = v_ok && h_ok && map_q[d_idx];
    d_clear = d_hit && !v_hit && !h_hit;
    clr_cnt = {1'b0, v_hit} + {1'b0, h_hit} + {1'b0, d_clear};
    clr_map = map_q;
    if (v_hit) begin
      clr_map[v_idx] = 1'b0;
    end
    if (h_hit) begin
      clr_map[h_idx] = 1'b0;
    end
    if (d_clear) begin
      clr_map[d_idx] = 1'b0;
    end
    left_after = left_q - {6'd0, clr_cnt};
    score_sum  = {1'b0, score_q} + {7'd0, clr_cnt};
    score_sat  = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  // Game state machine, step divider and board bookkeeping
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    map_d       = map_q;
    score_d     = score_q;
    left_d      = left_q;
    step_d      = 1'b0;
    restart_n_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          div_d   = '0;
        end
      end
      ST_RUN: begin
        if (ball_row == LAST_ROW) begin
          state_d = ST_LOST;
        end else begin
          if (step_q) begin
            map_d   = clr_map;
            score_d = score_sat;
            left_d  = left_after;
          end
          if (step_q && (clr_cnt != 2'd0) && (left_after == 8'd0)) begin
            state_d = ST_WON;
          end else if (pause) begin
            state_d = ST_PAUSE;
          end else if (div_q == LAST_DIV) begin
            div_d  = '0;
            step_d = 1'b1;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      ST_PAUSE: begin
        if (pause) begin
          state_d = ST_RUN;
        end
      end
      ST_WON, ST_LOST: begin
        if (start) begin
          state_d     = ST_IDLE;
          map_d       = INIT_MAP;
          score_d     = 8'd0;
          left_d      = INIT_LEFT;
          div_d       = '0;
          restart_n_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset to a fresh board
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      map_q       <= INIT_MAP;
      score_q     <= 8'd0;
      left_q      <= INIT_LEFT;
      step_q      <= 1'b0;
      restart_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      map_q       <= map_d;
      score_q     <= score_d;
      left_q      <= left_d;
      step_q      <= step_d;
      restart_n_q <= restart_n_d;
    end
  end

  assign brick_map      = map_q;
  assign ball_step      = step_q;
  assign ball_restart_n = restart_n_q;
  assign score          = score_q;
  assign bricks_left    = left_q;
  assign game_state     = state_q;

endmodule

// File: tb/tb_bricks_game_ctrl.sv
// Scoreboard bench for bricks_game_ctrl: a board-level reference model
// predicts every registered output each cycle and a monitor compares them.
module tb_bricks_game_ctrl;

  localparam int STEP_DIV   = 4;
  localparam int BRICK_ROWS = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic [3:0]   ball_row = 4'd8;
  logic [3:0]   ball_col = 4'd8;
  logic [1:0]   ball_dir = 2'd0;
  logic [191:0] brick_map;
  logic         ball_step;
  logic         ball_restart_n;
  logic [7:0]   score;
  logic [7:0]   bricks_left;
  logic [2:0]   game_state;

  bricks_game_ctrl #(
    .STEP_DIV  (STEP_DIV),
    .DIV_W     (4),
    .BRICK_ROWS(BRICK_ROWS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .pause         (pause),
    .ball_row      (ball_row),
    .ball_col      (ball_col),
    .ball_dir      (ball_dir),
    .brick_map     (brick_map),
    .ball_step     (ball_step),
    .ball_restart_n(ball_restart_n),
    .score         (score),
    .bricks_left   (bricks_left),
    .game_state    (game_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [191:0] map;
    logic         step;
    logic         restart_n;
    logic [7:0]   score;
    logic [7:0]   left;
    logic [2:0]   state;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: the board as a grid, the game as plain integers
  bit m_map[12][16];
  int m_state;
  int m_phase;
  int m_score;
  int m_left;
  bit m_step;
  bit m_restart_n;

  function automatic bit brickAt(int r, int c);
    if (r < 0 || r > 11 || c < 0 || c > 15) return 1'b0;
    return m_map[r][c];
  endfunction

  task automatic modelReload();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 16; c++)
        m_map[r][c] = (r < BRICK_ROWS);
    m_score = 0;
    m_left  = 16 * BRICK_ROWS;
  endtask

  task automatic modelEdge();
    bit nstep;
    bit nrst;
    int br, bc, vr, hc, cleared;
    bit v, h, dg;
    nstep = 1'b0;
    nrst  = 1'b1;
    br = int'(ball_row);
    bc = int'(ball_col);
    if (!reset) begin
      modelReload();
      m_state = 0;
      m_phase = 0;
    end else begin
      case (m_state)
        0: if (start) begin m_state = 1; m_phase = 0; end
        1: begin
          if (br == 11) begin
            m_state = 4;
          end else begin
            if (m_step) begin
              vr = br + (ball_dir[1] ? 1 : -1);
              hc = bc + (ball_dir[0] ? 1 : -1);
              v  = brickAt(vr, bc);
              h  = brickAt(br, hc);
              dg = brickAt(vr, hc);
              cleared = 0;
              if (v) begin m_map[vr][bc] = 1'b0; cleared++; end
              if (h) begin m_map[br][hc] = 1'b0; cleared++; end
              if (!v && !h && dg) begin m_map[vr][hc] = 1'b0; cleared++; end
              m_left  -= cleared;
              m_score += cleared;
              if (m_score > 255) m_score = 255;
            end
            if (m_left == 0) m_state = 3;
            else if (pause) m_state = 2;
            else if (m_phase == STEP_DIV - 1) begin m_phase = 0; nstep = 1'b1; end
            else m_phase++;
          end
        end
        2: if (pause) m_state = 1;
        default: begin
          if (start) begin
            modelReload();
            m_state = 0;
            m_phase = 0;
            nrst    = 1'b0;
          end
        end
      endcase
    end
    m_step      = nstep;
    m_restart_n = nrst;
  endtask

  function automatic exp_t modelSnapshot();
    exp_t e;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 16; c++)
        e.map[r * 16 + c] = m_map[r][c];
    e.step      = m_step;
    e.restart_n = m_restart_n;
    e.score     = 8'(m_score);
    e.left      = 8'(m_left);
    e.state     = 3'(m_state);
    return e;
  endfunction

  // Drive one cycle of inputs, let the model see the same edge, queue its answer
  task automatic applyStimulus(input bit st, input bit pa, input int r,
                               input int c, input int d);
    start    = st;
    pause    = pa;
    ball_row = 4'(r);
    ball_col = 4'(c);
    ball_dir = 2'(d);
    @(posedge clock);
    modelEdge();
    sb_q.push_back(modelSnapshot());
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n, input int r, input int c, input int d);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, r, c, d);
  endtask

  task automatic checkOutput(input exp_t e);
    n_tests += 6;
    if (brick_map !== e.map) begin
      n_fail++;
      $display("[TB] FAIL brick_map: got %h expected %h", brick_map, e.map);
    end
    if (ball_step !== e.step) begin
      n_fail++;
      $display("[TB] FAIL ball_step: got %b expected %b", ball_step, e.step);
    end
    if (ball_restart_n !== e.restart_n) begin
      n_fail++;
      $display("[TB] FAIL ball_restart_n: got %b expected %b", ball_restart_n, e.restart_n);
    end
    if (score !== e.score) begin
      n_fail++;
      $display("[TB] FAIL score: got %0d expected %0d", score, e.score);
    end
    if (bricks_left !== e.left) begin
      n_fail++;
      $display("[TB] FAIL bricks_left: got %0d expected %0d", bricks_left, e.left);
    end
    if (game_state !== e.state) begin
      n_fail++;
      $display("[TB] FAIL game_state: got %0d expected %0d", game_state, e.state);
    end
  endtask

  // Monitor: registered outputs are settled at the falling edge
  initial begin
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end
  end

  initial begin
    int guard;
    modelReload();
    m_state = 0; m_phase = 0; m_step = 0; m_restart_n = 1;

    // Power-on reset, then idle with an ignored pause
    idle(2, 8, 8, 0);
    reset = 1'b1;
    idle(2, 8, 8, 0);
    applyStimulus(1'b0, 1'b1, 8, 8, 0);
    idle(2, 8, 8, 0);

    // Start and watch the step strobe cadence away from any brick
    applyStimulus(1'b1, 1'b0, 8, 8, 0);
    idle(12, 8, 8, 0);

    // Vertical only, vertical+horizontal, diagonal only, horizontal only
    idle(STEP_DIV, 4, 5, 0);
    idle(STEP_DIV, 2, 5, 0);
    idle(STEP_DIV, 4, 5, 0);
    idle(STEP_DIV, 3, 8, 2);

    // Pause mid-count, hold 20 cycles, resume
    idle(1, 8, 8, 0);
    applyStimulus(1'b0, 1'b1, 8, 8, 0);
    idle(20, 8, 8, 0);
    applyStimulus(1'b0, 1'b1, 8, 8, 0);
    idle(8, 8, 8, 0);

    // Pause landing exactly when a step is due
    guard = 0;
    while (m_phase != STEP_DIV - 1 && guard < 2 * STEP_DIV) begin
      idle(1, 8, 8, 0);
      guard++;
    end
    applyStimulus(1'b0, 1'b1, 8, 8, 0);
    idle(5, 8, 8, 0);
    applyStimulus(1'b1, 1'b1, 8, 8, 0);
    applyStimulus(1'b0, 1'b1, 8, 8, 0);
    idle(6, 8, 8, 0);

    // Ball reaches the bottom row, then restart
    idle(4, 11, 5, 2);
    applyStimulus(1'b1, 1'b0, 11, 5, 2);
    idle(3, 8, 8, 0);

    // Randomised play
    for (int i = 0; i < 1500; i++) begin
      bit st, pa;
      int r;
      st = ($urandom_range(0, 99) < 3);
      pa = ($urandom_range(0, 99) < 3);
      r  = ($urandom_range(0, 99) < 1) ? 11 : int'($urandom_range(0, 10));
      applyStimulus(st, pa, r, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    // Fresh board, then sweep the ball under every brick until the game is won
    reset = 1'b0;
    idle(1, 8, 8, 0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 8, 8, 0);
    for (int r = BRICK_ROWS - 1; r >= 0; r--)
      for (int c = 0; c < 16; c++)
        idle(STEP_DIV, r + 1, c, 0);
    idle(4, 5, 5, 0);

    // Reset while in the won state
    reset = 1'b0;
    idle(2, 5, 5, 0);
    reset = 1'b1;
    idle(3, 8, 8, 0);

    repeat (2) @(negedge clock);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
